// File: rtl/serial_tx_master.sv
// Serial write-frame master: address, RW bit and data go out MSB first, then it waits for the slave acknowledge.
// Optional even parity bit after the data when SERIAL_TX_PARITY_EN is defined.
module serial_tx_master #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDRS_WIDTH = 15,
  parameter int TIMEOUT_LEN = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tx_start,
  input  logic [ADDRS_WIDTH-1:0] tx_address,
  input  logic [DATA_WIDTH-1:0]  tx_data,
  output logic                   tx_busy,
  output logic                   tx_done,
  output logic                   tx_timeout,
  inout  wire                    bus_util,
  inout  wire                    data_bus_serial,
  inout  wire                    slave_busy
);

  localparam int MAXW = (ADDRS_WIDTH > DATA_WIDTH) ? ADDRS_WIDTH : DATA_WIDTH;
  localparam int BW   = $clog2(MAXW + 1);

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_RW, S_DATA, S_PAR, S_WAIT
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_RW, S_DATA, S_WAIT
  } state_t;
`endif

  state_t state, state_n;

  logic [ADDRS_WIDTH-1:0] addr_sr;
  logic [DATA_WIDTH-1:0]  data_sr;
  logic [BW-1:0]          bit_cnt;
  logic [TIMEOUT_LEN-1:0] wait_cnt;
  logic                   accept;
  logic                   done_n;
  logic                   tout_n;
  logic                   drive;
  logic                   bit_o;
`ifdef SERIAL_TX_PARITY_EN
  logic                   par_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    done_n  = 1'b0;
    tout_n  = 1'b0;
    drive   = 1'b0;
    bit_o   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (tx_start) begin
          accept  = 1'b1;
          state_n = S_ADDR;
        end
      end
      S_ADDR: begin
        drive = 1'b1;
        bit_o = addr_sr[ADDRS_WIDTH-1];
        if (bit_cnt == '0) state_n = S_RW;
      end
      S_RW: begin
        drive   = 1'b1;
        bit_o   = 1'b1;
        state_n = S_DATA;
      end
      S_DATA: begin
        drive = 1'b1;
        bit_o = data_sr[DATA_WIDTH-1];
`ifdef SERIAL_TX_PARITY_EN
        if (bit_cnt == '0) state_n = S_PAR;
`else
        if (bit_cnt == '0) state_n = S_WAIT;
`endif
      end
`ifdef SERIAL_TX_PARITY_EN
      S_PAR: begin
        drive   = 1'b1;
        bit_o   = par_q;
        state_n = S_WAIT;
      end
`endif
      S_WAIT: begin
        // Acknowledge wins over an expiry on the same edge
        if (slave_busy == 1'b0) begin
          done_n  = 1'b1;
          state_n = S_IDLE;
        end else if (&wait_cnt) begin
          tout_n  = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_sr    <= '0;
      data_sr    <= '0;
      bit_cnt    <= '0;
      wait_cnt   <= '0;
      tx_done    <= 1'b0;
      tx_timeout <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      tx_done    <= done_n;
      tx_timeout <= tout_n;
      wait_cnt   <= (state == S_WAIT) ? wait_cnt + 1'b1 : '0;
      if (accept) begin
        addr_sr <= tx_address;
        data_sr <= tx_data;
        bit_cnt <= BW'(ADDRS_WIDTH - 1);
`ifdef SERIAL_TX_PARITY_EN
        par_q   <= ^tx_data;
`endif
      end
      if (state == S_ADDR) begin
        addr_sr <= addr_sr << 1;
        bit_cnt <= (bit_cnt == '0) ? BW'(DATA_WIDTH - 1)
                                   : bit_cnt - 1'b1;
      end
      if (state == S_DATA) begin
        data_sr <= data_sr << 1;
        if (bit_cnt != '0) bit_cnt <= bit_cnt - 1'b1;
      end
    end
  end

  assign tx_busy         = (state != S_IDLE);
  assign bus_util        = tx_busy ? 1'b1 : 1'bz;
  assign data_bus_serial = drive ? bit_o : 1'bz;

endmodule

// File: tb/tb_serial_tx_master.sv
// Randomized bench for serial_tx_master against a frame-level reference model.
// Released lines are read through a pulldown (bus_util) and a pullup (data_bus_serial).
module tb_serial_tx_master;

  localparam int DW  = 8;
  localparam int AW  = 15;
  localparam int TL  = 6;
  localparam int TMO = 1 << TL;
`ifdef SERIAL_TX_PARITY_EN
  localparam int NB  = AW + 1 + DW + 1;
`else
  localparam int NB  = AW + 1 + DW;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          tx_start = 1'b0;
  logic [AW-1:0] tx_address = '0;
  logic [DW-1:0] tx_data = '0;
  logic          tx_busy;
  logic          tx_done;
  logic          tx_timeout;
  logic          sb = 1'b1;
  wire           bus_util;
  wire           data_bus_serial;
  wire           slave_busy;

  int checks = 0;
  int errors = 0;
  logic exp_bits[$];

  assign slave_busy = sb;
  pulldown (bus_util);
  pullup (data_bus_serial);

  always #5 clk = ~clk;

  serial_tx_master #(
    .DATA_WIDTH (DW),
    .ADDRS_WIDTH(AW),
    .TIMEOUT_LEN(TL)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .tx_start       (tx_start),
    .tx_address     (tx_address),
    .tx_data        (tx_data),
    .tx_busy        (tx_busy),
    .tx_done        (tx_done),
    .tx_timeout     (tx_timeout),
    .bus_util       (bus_util),
    .data_bus_serial(data_bus_serial),
    .slave_busy     (slave_busy)
  );

  function automatic void build_bits(input logic [AW-1:0] a,
                                     input logic [DW-1:0] d);
    exp_bits.delete();
    for (int i = AW - 1; i >= 0; i--) exp_bits.push_back(a[i]);
    exp_bits.push_back(1'b1);
    for (int i = DW - 1; i >= 0; i--) exp_bits.push_back(d[i]);
`ifdef SERIAL_TX_PARITY_EN
    exp_bits.push_back(^d);
`endif
  endfunction

  // Vector: {busy, bus_util, data_bus_serial, done, timeout}
  task automatic run_frame(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int ack_bit, input bit hold,
                           input string tag);
    int   wait_ack;
    int   end_c;
    bit   exp_done;
    logic [4:0] got;
    logic [4:0] exp;
    build_bits(a, d);
    wait_ack = (ack_bit < NB) ? 0 : ack_bit - NB;
    if (ack_bit >= 0 && wait_ack < TMO) begin
      exp_done = 1'b1;
      end_c    = NB + wait_ack + 1;
    end else begin
      exp_done = 1'b0;
      end_c    = NB + TMO;
    end
    tx_start   = 1'b1;
    tx_address = a;
    tx_data    = d;
    for (int c = 0; c <= end_c; c++) begin
      @(negedge clk);
      got = {tx_busy, bus_util, data_bus_serial, tx_done, tx_timeout};
      if (c < NB)          exp = {2'b11, exp_bits[c], 2'b00};
      else if (c < end_c)  exp = 5'b11100;
      else                 exp = {3'b001, exp_done, ~exp_done};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s clk %0d got %b expected %b", tag, c, got, exp);
      end
      if (!hold) tx_start = (c == 10);
      tx_address = AW'($urandom);
      tx_data    = (c == 10) ? '1 : DW'($urandom);
      sb = (ack_bit >= 0 && c >= ack_bit) ? 1'b0 : 1'b1;
    end
  endtask

  task automatic idle_check(input int n, input string tag);
    logic [4:0] got;
    tx_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      got = {tx_busy, bus_util, data_bus_serial, tx_done, tx_timeout};
      checks++;
      if (got !== 5'b00100) begin
        errors++;
        $display("FAIL %s idle %0d got %b expected 00100", tag, i, got);
      end
    end
  endtask

  task automatic test_reset();
    logic [4:0] got;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    got = {tx_busy, bus_util, data_bus_serial, tx_done, tx_timeout};
    checks++;
    if (got !== 5'b00100) begin
      errors++;
      $display("FAIL reset got %b expected 00100", got);
    end
    rst = 1'b0;
    idle_check(2, "post_reset");
  endtask

  task automatic test_basic();
    run_frame(15'h0005, 8'hA5, 20, 1'b0, "basic_a5");
    idle_check(2, "basic_idle");
  endtask

  task automatic test_timeout();
    run_frame(AW'($urandom), DW'($urandom), -1, 1'b0, "timeout");
    idle_check(2, "timeout_idle");
  endtask

  task automatic test_ack_at_expiry();
    run_frame(AW'($urandom), DW'($urandom), NB + TMO - 1, 1'b0, "ack_expiry");
    idle_check(1, "ack_expiry_idle");
    run_frame(AW'($urandom), DW'($urandom), NB + TMO - 2, 1'b0, "ack_before");
    idle_check(1, "ack_before_idle");
  endtask

  task automatic test_ignore_start();
    run_frame(15'h1234, 8'h5A, NB + 3, 1'b0, "ignore_start");
    idle_check(2, "ignore_idle");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      run_frame(AW'($urandom), DW'($urandom),
                int'($urandom_range(NB, NB + 10)), 1'b1, "b2b");
    idle_check(2, "b2b_idle");
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 20; i++) begin
      r = int'($urandom_range(0, NB + TMO + 8));
      if (r > NB + TMO + 4) r = -1;
      run_frame(AW'($urandom), DW'($urandom), r, 1'b0, "random");
      idle_check(int'($urandom_range(1, 3)), "random_idle");
    end
  endtask

  task automatic test_reset_midframe();
    logic [4:0] got;
    tx_start   = 1'b1;
    tx_address = AW'($urandom);
    tx_data    = DW'($urandom);
    for (int c = 0; c <= AW + 1 + 3; c++) begin
      @(negedge clk);
      tx_start = 1'b0;
    end
    checks++;
    if (tx_busy !== 1'b1) begin
      errors++;
      $display("FAIL midframe_busy got %b expected 1", tx_busy);
    end
    rst = 1'b1;
    #1;
    got = {tx_busy, bus_util, data_bus_serial, tx_done, tx_timeout};
    checks++;
    if (got !== 5'b00100) begin
      errors++;
      $display("FAIL midframe_reset got %b expected 00100", got);
    end
    @(negedge clk);
    got = {tx_busy, bus_util, data_bus_serial, tx_done, tx_timeout};
    checks++;
    if (got !== 5'b00100) begin
      errors++;
      $display("FAIL midframe_hold got %b expected 00100", got);
    end
    rst = 1'b0;
    run_frame(AW'($urandom), 8'h3C, NB + 5, 1'b0, "after_reset_3c");
    idle_check(2, "after_reset_idle");
  endtask

  task automatic test_parity();
    run_frame(AW'($urandom), 8'h07, NB + 1, 1'b0, "parity_07");
    idle_check(1, "parity_idle");
    run_frame(AW'($urandom), 8'h03, NB + 1, 1'b0, "parity_03");
    idle_check(1, "parity_idle");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_ack_at_expiry();
    test_ignore_start();
    test_back_to_back();
    test_random();
    test_reset_midframe();
    test_parity();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
